// File: rtl/hps_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hps_reset_sequencer
// Purpose  : Captures edges on asynchronous per-channel reset requests and
//            serialises them into one reset pulse at a time. Each channel has
//            its own pulse length, and a fixed idle holdoff follows every
//            pulse. Channel 0 has the highest priority.
// Ports    : clk         - sole clock, rising edge
//            reset_n     - asynchronous active-low reset
//            req_in      - per-channel request levels (asynchronous)
//            rst_out     - per-channel active-high reset pulses (one-hot/zero)
//            busy        - high while pulsing or in holdoff
//            active_ch   - index of the channel last granted
//            pending     - sticky captured-request flags
//            req_dropped - one-clock pulse when an edge hits a pending channel
// Revision : 1.0 - initial release
// ============================================================================
module hps_reset_sequencer #(
    parameter int                          NUM_CH    = 3,
    parameter int                          CH_W      = 2,
    parameter int                          PULSE_W   = 6,
    parameter logic [NUM_CH*PULSE_W-1:0]   PULSE_LEN = {6'd32, 6'd2, 6'd6},
    parameter int                          EDGE_TYPE = 1,
    parameter int                          HOLDOFF   = 4,
    parameter int                          HOLDOFF_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] req_in,
    output logic [NUM_CH-1:0] rst_out,
    output logic              busy,
    output logic [CH_W-1:0]   active_ch,
    output logic [NUM_CH-1:0] pending,
    output logic              req_dropped
);

    // One counter serves both the pulse and the holdoff phases.
    localparam int                c_cnt_w    = (PULSE_W > HOLDOFF_W) ? PULSE_W : HOLDOFF_W;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_holdoff  = c_cnt_w'(HOLDOFF);
    // Inactive request level: synchroniser starts here so a request already
    // asserted when reset releases is seen as a fresh edge.
    localparam logic [NUM_CH-1:0] c_inactive = (EDGE_TYPE == 1) ? '0 : '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    logic [NUM_CH-1:0]  r_sync1, r_sync2, r_hist;
    logic [NUM_CH-1:0]  r_pending, r_rst_out;
    logic               r_dropped;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [CH_W-1:0]    r_active_ch;

    logic [NUM_CH-1:0]  w_edge;
    logic [NUM_CH-1:0]  w_grant;
    logic [CH_W-1:0]    w_grant_idx;
    logic [PULSE_W-1:0] w_grant_len;
    logic [NUM_CH-1:0]  w_clear;
    state_t             w_next_state;
    logic [c_cnt_w-1:0] w_next_cnt;
    logic [CH_W-1:0]    w_next_active;
    logic [NUM_CH-1:0]  w_next_rst_out;
    logic [NUM_CH-1:0]  w_next_pending;
    logic               w_next_dropped;

    // Synchroniser plus history stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= c_inactive;
            r_sync2 <= c_inactive;
            r_hist  <= c_inactive;
        end else begin
            r_sync1 <= req_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    always_comb begin
        if (EDGE_TYPE == 1) w_edge = r_sync2 & ~r_hist;
        else                w_edge = ~r_sync2 & r_hist;
    end

    // Lowest set pending index wins: scan downwards so the last hit is lowest.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_grant_len = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_grant     = '0;
                w_grant[i]  = 1'b1;
                w_grant_idx = CH_W'(i);
                w_grant_len = PULSE_LEN[i*PULSE_W +: PULSE_W];
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_active  = r_active_ch;
        w_next_rst_out = r_rst_out;
        w_clear        = '0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_next_state   = ST_PULSE;
                    // A zero-length field still yields a one-clock pulse.
                    w_next_cnt     = (w_grant_len == '0) ? c_cnt_one : c_cnt_w'(w_grant_len);
                    w_next_active  = w_grant_idx;
                    w_next_rst_out = w_grant;
                    w_clear        = w_grant;
                end
            end
            ST_PULSE: begin
                if (r_cnt <= c_cnt_one) begin
                    w_next_rst_out = '0;
                    if (HOLDOFF == 0) begin
                        w_next_state = ST_IDLE;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_state = ST_HOLDOFF;
                        w_next_cnt   = c_holdoff;
                    end
                end else begin
                    w_next_cnt = r_cnt - c_cnt_one;
                end
            end
            ST_HOLDOFF: begin
                if (r_cnt <= c_cnt_one) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt - c_cnt_one;
                end
            end
            default: begin
                w_next_state   = ST_IDLE;
                w_next_cnt     = '0;
                w_next_rst_out = '0;
            end
        endcase
    end

    // A new edge beats a simultaneous grant clear, and is then not a drop.
    always_comb begin
        w_next_pending = (r_pending & ~w_clear) | w_edge;
        w_next_dropped = |(w_edge & r_pending & ~w_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_active_ch <= '0;
            r_rst_out   <= '0;
            r_pending   <= '0;
            r_dropped   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_active_ch <= w_next_active;
            r_rst_out   <= w_next_rst_out;
            r_pending   <= w_next_pending;
            r_dropped   <= w_next_dropped;
        end
    end

    assign rst_out     = r_rst_out;
    assign busy        = (r_state != ST_IDLE);
    assign active_ch   = r_active_ch;
    assign pending     = r_pending;
    assign req_dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_hps_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hps_reset_sequencer
// Purpose  : Directed self-checking bench. Instance a uses default parameters;
//            instance b uses falling-edge triggering, a zero-length pulse on
//            channel 1 and no holdoff.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hps_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic [2:0] req_a, rst_a, pend_a;
    logic [1:0] ch_a;
    logic       busy_a, drop_a;
    logic [2:0] req_b, rst_b, pend_b;
    logic [1:0] ch_b;
    logic       busy_b, drop_b;

    int total;
    int bad;

    hps_reset_sequencer dut_a (
        .clk(clk), .reset_n(reset_n), .req_in(req_a), .rst_out(rst_a),
        .busy(busy_a), .active_ch(ch_a), .pending(pend_a), .req_dropped(drop_a)
    );

    hps_reset_sequencer #(
        .NUM_CH(3), .CH_W(2), .PULSE_W(6),
        .PULSE_LEN({6'd5, 6'd0, 6'd3}),
        .EDGE_TYPE(0), .HOLDOFF(0), .HOLDOFF_W(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .req_in(req_b), .rst_out(rst_b),
        .busy(busy_b), .active_ch(ch_b), .pending(pend_b), .req_dropped(drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        tick(3);
        total++; if (rst_a !== 3'b000) begin bad++; $display("FAIL reset_rst_a got %b want 000", rst_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
        total++; if (pend_a !== 3'b000) begin bad++; $display("FAIL reset_pend_a got %b want 000", pend_a); end
        total++; if (ch_a !== 2'd0) begin bad++; $display("FAIL reset_ch_a got %0d want 0", ch_a); end
        total++; if (drop_a !== 1'b0) begin bad++; $display("FAIL reset_drop_a got %b want 0", drop_a); end
        total++; if ({rst_b, busy_b, pend_b} !== 7'd0) begin bad++; $display("FAIL reset_b got %b want 0", {rst_b, busy_b, pend_b}); end
        reset_n = 1'b1;
        tick(5);
        total++; if (rst_a !== 3'b000 || rst_b !== 3'b000) begin bad++; $display("FAIL post_release_idle got %b/%b want 000/000", rst_a, rst_b); end
    endtask

    task automatic test_single();
        int hi, bz;
        hi = 0; bz = 0;
        req_a[0] = 1'b1;
        tick(3);
        total++; if (pend_a !== 3'b001) begin bad++; $display("FAIL single_pending got %b want 001", pend_a); end
        total++; if (rst_a !== 3'b000) begin bad++; $display("FAIL single_early got %b want 000", rst_a); end
        tick(1);
        total++; if (rst_a !== 3'b001) begin bad++; $display("FAIL single_latency got %b want 001", rst_a); end
        total++; if (pend_a !== 3'b000) begin bad++; $display("FAIL single_clear got %b want 000", pend_a); end
        for (int j = 0; j < 20; j++) begin
            if (rst_a === 3'b001) hi++;
            if (busy_a === 1'b1) bz++;
            tick(1);
        end
        total++; if (hi != 6) begin bad++; $display("FAIL single_pulse_len got %0d want 6", hi); end
        total++; if (bz != 10) begin bad++; $display("FAIL single_busy_len got %0d want 10", bz); end
        total++; if (ch_a !== 2'd0) begin bad++; $display("FAIL single_active_ch got %0d want 0", ch_a); end
        req_a[0] = 1'b0;
        tick(4);
    endtask

    task automatic test_two_ch();
        int hi;
        hi = 0;
        req_a = 3'b110;
        tick(3);
        total++; if (pend_a !== 3'b110) begin bad++; $display("FAIL two_pending got %b want 110", pend_a); end
        tick(1);
        total++; if (rst_a !== 3'b010) begin bad++; $display("FAIL two_ch1_start got %b want 010", rst_a); end
        total++; if (pend_a !== 3'b100) begin bad++; $display("FAIL two_pending_mid got %b want 100", pend_a); end
        total++; if (ch_a !== 2'd1) begin bad++; $display("FAIL two_active1 got %0d want 1", ch_a); end
        tick(1);
        total++; if (rst_a !== 3'b010) begin bad++; $display("FAIL two_ch1_second got %b want 010", rst_a); end
        tick(1);
        total++; if (rst_a !== 3'b000 || busy_a !== 1'b1) begin bad++; $display("FAIL two_holdoff got %b/%b want 000/1", rst_a, busy_a); end
        tick(4);
        total++; if (busy_a !== 1'b0 || rst_a !== 3'b000) begin bad++; $display("FAIL two_idle_gap got %b/%b want 0/000", busy_a, rst_a); end
        tick(1);
        total++; if (rst_a !== 3'b100) begin bad++; $display("FAIL two_ch2_start got %b want 100", rst_a); end
        total++; if (pend_a !== 3'b000) begin bad++; $display("FAIL two_pending_end got %b want 000", pend_a); end
        total++; if (ch_a !== 2'd2) begin bad++; $display("FAIL two_active2 got %0d want 2", ch_a); end
        for (int j = 0; j < 40; j++) begin
            if (rst_a === 3'b100) hi++;
            tick(1);
        end
        total++; if (hi != 32) begin bad++; $display("FAIL two_ch2_len got %0d want 32", hi); end
        req_a = 3'b000;
        tick(3);
    endtask

    task automatic test_dropped();
        int drops, ch1hi, rises;
        logic prev;
        drops = 0; ch1hi = 0; rises = 0; prev = 1'b0;
        req_a = 3'b100;
        tick(4);
        total++; if (rst_a !== 3'b100) begin bad++; $display("FAIL drop_ch2_start got %b want 100", rst_a); end
        for (int j = 0; j < 70; j++) begin
            if (drop_a === 1'b1) drops++;
            if (rst_a[1] === 1'b1) ch1hi++;
            if (rst_a[1] === 1'b1 && !prev) rises++;
            prev = rst_a[1];
            if (j == 0) req_a[1] = 1'b1;
            if (j == 4) req_a[1] = 1'b0;
            if (j == 8) req_a[1] = 1'b1;
            tick(1);
        end
        total++; if (drops != 1) begin bad++; $display("FAIL drop_count got %0d want 1", drops); end
        total++; if (ch1hi != 2) begin bad++; $display("FAIL drop_ch1_len got %0d want 2", ch1hi); end
        total++; if (rises != 1) begin bad++; $display("FAIL drop_ch1_grants got %0d want 1", rises); end
        total++; if (pend_a !== 3'b000) begin bad++; $display("FAIL drop_pending got %b want 000", pend_a); end
        req_a = 3'b000;
        tick(3);
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        req_a = 3'b100;
        tick(4);
        total++; if (rst_a !== 3'b100) begin bad++; $display("FAIL mid_start got %b want 100", rst_a); end
        req_a[1] = 1'b1;
        tick(3);
        total++; if (pend_a !== 3'b010 || rst_a !== 3'b100) begin bad++; $display("FAIL mid_setup got %b/%b want 010/100", pend_a, rst_a); end
        reset_n = 1'b0;
        #1;
        total++; if (rst_a !== 3'b000) begin bad++; $display("FAIL mid_async_drop got %b want 000", rst_a); end
        total++; if (pend_a !== 3'b000 || busy_a !== 1'b0) begin bad++; $display("FAIL mid_discard got %b/%b want 000/0", pend_a, busy_a); end
        req_a = 3'b000;
        tick(3);
        reset_n = 1'b1;
        for (int j = 0; j < 50; j++) begin
            if (rst_a !== 3'b000 || pend_a !== 3'b000) stray++;
            tick(1);
        end
        total++; if (stray != 0) begin bad++; $display("FAIL mid_no_pulse got %0d want 0", stray); end
    endtask

    task automatic test_held_reset();
        int hi, rises;
        logic prev;
        hi = 0; rises = 0; prev = 1'b0;
        reset_n = 1'b0;
        req_a = 3'b001;
        tick(2);
        reset_n = 1'b1;
        for (int j = 0; j < 60; j++) begin
            if (rst_a === 3'b001) hi++;
            if (rst_a[0] === 1'b1 && !prev) rises++;
            prev = rst_a[0];
            tick(1);
        end
        total++; if (hi != 6) begin bad++; $display("FAIL held_pulse_len got %0d want 6", hi); end
        total++; if (rises != 1) begin bad++; $display("FAIL held_pulse_count got %0d want 1", rises); end
        req_a = 3'b000;
        tick(3);
    endtask

    task automatic test_falling();
        req_b[1] = 1'b0;
        tick(3);
        total++; if (pend_b !== 3'b010 || rst_b !== 3'b000) begin bad++; $display("FAIL fall_pending got %b/%b want 010/000", pend_b, rst_b); end
        tick(1);
        total++; if (rst_b !== 3'b010 || busy_b !== 1'b1) begin bad++; $display("FAIL fall_pulse got %b/%b want 010/1", rst_b, busy_b); end
        total++; if (ch_b !== 2'd1) begin bad++; $display("FAIL fall_active got %0d want 1", ch_b); end
        tick(1);
        total++; if (rst_b !== 3'b000 || busy_b !== 1'b0) begin bad++; $display("FAIL fall_end got %b/%b want 000/0", rst_b, busy_b); end
        req_b[1] = 1'b1;
        tick(3);
        total++; if (rst_b !== 3'b000 || pend_b !== 3'b000) begin bad++; $display("FAIL fall_rise_ignored got %b/%b want 000/000", rst_b, pend_b); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        req_a   = 3'b000;
        req_b   = 3'b111;
        test_reset();
        test_single();
        test_two_ch();
        test_dropped();
        test_reset_mid();
        test_held_reset();
        test_falling();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hps_reset_sequencer.md
HPS_RESET_SEQUENCER -- requirements
Module: hps_reset_sequencer

Interface
REQ-001 Parameter NUM_CH, default 3: number of reset request channels, range 1..8; channel 0 has highest priority.
REQ-002 Parameter CH_W, default 2: width of active_ch, >= ceil(log2(NUM_CH)), minimum 1.
REQ-003 Parameter PULSE_W, default 6: width of each per-channel pulse-length field.
REQ-004 Parameter PULSE_LEN, default {6'd32, 6'd2, 6'd6}: packed NUM_CH*PULSE_W vector; field i, bits [i*PULSE_W +: PULSE_W], is the pulse length of channel i in clocks.
REQ-005 Parameter EDGE_TYPE, default 1: 1 = rising-edge trigger, 0 = falling-edge trigger.
REQ-006 Parameter HOLDOFF, default 4: idle clocks enforced after every pulse; HOLDOFF_W, default 4, is the width of the holdoff counter.
REQ-007 clk  input  1  sole clock, all logic on rising edge.
REQ-008 reset_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk.
REQ-009 req_in  input  NUM_CH  per-channel reset request levels, asynchronous to clk.
REQ-010 rst_out  output  NUM_CH  per-channel active-high reset pulses; at most one bit set at any time.
REQ-011 busy  output  1  high in PULSE and HOLDOFF states.
REQ-012 active_ch  output  CH_W  index of the channel last granted.
REQ-013 pending  output  NUM_CH  sticky per-channel captured-request flags.
REQ-014 req_dropped  output  1  one-clock pulse when an edge arrives on a channel whose pending bit is already set.

Function
REQ-015 Each req_in bit SHALL pass through a 2-flop synchroniser followed by a history flop; an edge is detected when sync2 differs from history in the EDGE_TYPE direction.
REQ-016 A detected edge SHALL set pending[i] on the following clock; if pending[i] is already 1 at that time, the bit stays 1 and req_dropped pulses for exactly one clock.
REQ-017 The FSM SHALL have states IDLE, PULSE, and HOLDOFF.
REQ-018 In IDLE with pending != 0, the FSM SHALL grant the lowest set index i on the next clock: clear pending[i], set active_ch=i, load the counter with max(PULSE_LEN[i],1), assert rst_out[i], and enter PULSE.
REQ-019 PULSE SHALL hold rst_out[i] high for exactly max(PULSE_LEN[i],1) consecutive clocks, then deassert it and enter HOLDOFF with counter=HOLDOFF.
REQ-020 If HOLDOFF=0, the FSM SHALL go from PULSE directly to IDLE.
REQ-021 HOLDOFF SHALL last exactly HOLDOFF clocks, then return to IDLE; the earliest next grant is the clock after IDLE is entered.
REQ-022 Edges arriving in PULSE or HOLDOFF, including on the active channel, SHALL set pending per REQ-016 and be serviced later; they SHALL NOT extend or restart the current pulse.
REQ-023 When a grant clears pending[i] on the same clock that a new edge on channel i would set it, the set SHALL win; req_dropped SHALL NOT pulse.
REQ-024 Latency: req_in toggling before clock edge k SHALL produce the first rst_out high after edge k+3 when the FSM is IDLE.
REQ-025 active_ch SHALL hold its value after the pulse ends until the next grant.

Reset
REQ-026 While reset_n=0: rst_out=0, busy=0, pending=0, active_ch=0, req_dropped=0, state=IDLE, counters=0.
REQ-027 Synchroniser and history flops SHALL reset to the inactive level (0 if EDGE_TYPE=1, 1 if EDGE_TYPE=0), so a request already active at reset release SHALL trigger one pulse.
REQ-028 Reset asserted mid-pulse SHALL drop rst_out immediately (asynchronously) and discard all pending requests.

Verification (defaults: NUM_CH=3, PULSE_LEN ch0=6, ch1=2, ch2=32, HOLDOFF=4)
REQ-029 Rising edge on req_in[0] -> rst_out[0] high 6 clocks starting at edge k+3; busy high 10 clocks; active_ch=0.
REQ-030 Edges on req_in[2] and req_in[1] in the same clock -> ch1 pulses for 2 clocks, 4 idle clocks, then ch2 pulses for 32 clocks; pending goes 110 -> 100 -> 000.
REQ-031 Two edges on req_in[1] during a ch2 pulse -> req_dropped pulses once; ch1 is serviced exactly once afterwards.
REQ-032 reset_n low at clock 3 of a ch2 pulse -> rst_out=0 within the same cycle; after release with req_in=000, no pulse occurs.
REQ-033 req_in[0]=1 held through reset release -> exactly one 6-clock pulse on rst_out[0]; no further pulses while the level is held.
REQ-034 EDGE_TYPE=0, PULSE_LEN ch1=0, HOLDOFF=0 -> a falling edge on req_in[1] gives a 1-clock rst_out[1] and busy returns to 0 on the next clock.
